// File: rtl/gate_deadtime_water_pkg.sv
// Shared constants and leg state encoding for the gate dead-time stage.
package gate_deadtime_water_pkg;
    localparam logic [31:0] ONE_SINGLE  = 32'h3F800000;
    localparam logic [31:0] ZERO_SINGLE = 32'h00000000;
    localparam int          CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_UPPER = 2'd1,
        ST_LOWER = 2'd2,
        ST_DEAD  = 2'd3
    } leg_state_e;

    // Sign bit ignored so that -0.0 decodes as off.
    function automatic logic is_on(input logic [31:0] f);
        return |f[30:0];
    endfunction
endpackage

// File: rtl/gate_deadtime_water_if.sv
// Step/command/switch-state bundle between the control stage and the solver.
// Optional GATE_STATS_EN adds per-leg commutation counters.
interface gate_deadtime_water_if;
    logic        sta;
    logic [31:0] m1_single, m3_single, m5_single;
    logic [31:0] s1_single, s2_single, s3_single, s4_single, s5_single, s6_single;
    logic        sw_event;
    logic        done_sig;
`ifdef GATE_STATS_EN
    logic [15:0] sw_cnt_a, sw_cnt_b, sw_cnt_c;
`endif

    modport master (
        output sta, m1_single, m3_single, m5_single,
        input  s1_single, s2_single, s3_single, s4_single, s5_single, s6_single,
        input  sw_event, done_sig
`ifdef GATE_STATS_EN
        , input sw_cnt_a, sw_cnt_b, sw_cnt_c
`endif
    );

    modport slave (
        input  sta, m1_single, m3_single, m5_single,
        output s1_single, s2_single, s3_single, s4_single, s5_single, s6_single,
        output sw_event, done_sig
`ifdef GATE_STATS_EN
        , output sw_cnt_a, sw_cnt_b, sw_cnt_c
`endif
    );
endinterface

// File: rtl/gate_deadtime_water_leg.sv
// One converter leg: START/UPPER/LOWER/DEAD FSM with step-counted blanking.
// GATE_STATS_EN adds a saturating commutation counter.
module gate_deadtime_leg
    import gate_deadtime_water_pkg::*;
#(
    parameter int unsigned DEADTIME_STEPS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        step,
    input  logic        cmd,
    output logic        up,
    output logic        dn,
    output logic        changed
`ifdef GATE_STATS_EN
    , output logic [15:0] sw_cnt
`endif
);
    localparam logic [CNT_W-1:0] DT = CNT_W'(DEADTIME_STEPS);

    leg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_START;
            cnt_q   <= '0;
        end else if (clr) begin
            state_q <= ST_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (step) begin
            case (state_q)
                ST_START: begin
                    if (DT == '0) state_d = cmd ? ST_UPPER : ST_LOWER;
                    else begin
                        state_d = ST_DEAD;
                        cnt_d   = DT;
                    end
                end
                ST_UPPER: begin
                    if (!cmd) begin
                        if (DT == '0) state_d = ST_LOWER;
                        else begin
                            state_d = ST_DEAD;
                            cnt_d   = DT;
                        end
                    end
                end
                ST_LOWER: begin
                    if (cmd) begin
                        if (DT == '0) state_d = ST_UPPER;
                        else begin
                            state_d = ST_DEAD;
                            cnt_d   = DT;
                        end
                    end
                end
                default: begin
                    // Reversals while blanking are ignored; only the exit command counts.
                    if (cnt_q > 8'd1) cnt_d = cnt_q - 8'd1;
                    else              state_d = cmd ? ST_UPPER : ST_LOWER;
                end
            endcase
        end
    end

    // Next-state view so the top can register the float outputs on the step edge.
    assign up      = (state_d == ST_UPPER);
    assign dn      = (state_d == ST_LOWER);
    assign changed = ((state_d == ST_UPPER) != (state_q == ST_UPPER)) |
                     ((state_d == ST_LOWER) != (state_q == ST_LOWER));

`ifdef GATE_STATS_EN
    logic [15:0] sw_cnt_q;
    logic        commut;

    assign commut = ((state_q == ST_UPPER) || (state_q == ST_LOWER)) && (state_d != state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   sw_cnt_q <= '0;
        else if (clr)                              sw_cnt_q <= '0;
        else if (commut && (sw_cnt_q != 16'hFFFF)) sw_cnt_q <= sw_cnt_q + 16'd1;
    end

    assign sw_cnt = sw_cnt_q;
`endif
endmodule

// File: rtl/gate_deadtime_water.sv
// Three-leg gate generator with dead-time blanking, step pipeline and change flag.
// Define GATE_STATS_EN for per-leg saturating commutation counters.
module gate_deadtime_water #(
    parameter int unsigned DEADTIME_STEPS = 2,
    parameter logic [31:0] ONE_SINGLE     = gate_deadtime_water_pkg::ONE_SINGLE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_user,
    gate_deadtime_water_if.slave  bus
);
    import gate_deadtime_water_pkg::*;

    localparam int STAGES = 1;

    logic              step;
    logic [2:0]        cmd, up, dn, chg;
    logic [STAGES:0]   vld_pipe_q;
    logic              chg_q, sw_event_q;
    logic [5:0][31:0]  s_q;

    // User reset wins over a coincident step.
    assign step = bus.sta & ~rst_user;
    assign cmd  = {is_on(bus.m5_single), is_on(bus.m3_single), is_on(bus.m1_single)};

`ifdef GATE_STATS_EN
    logic [2:0][15:0] sw_cnt;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_leg
        gate_deadtime_leg #(.DEADTIME_STEPS(DEADTIME_STEPS)) u_leg (
            .clk     (clk),
            .rst     (rst),
            .clr     (rst_user),
            .step    (step),
            .cmd     (cmd[i]),
            .up      (up[i]),
            .dn      (dn[i]),
            .changed (chg[i])
`ifdef GATE_STATS_EN
            , .sw_cnt (sw_cnt[i])
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            chg_q      <= 1'b0;
            sw_event_q <= 1'b0;
            s_q        <= '0;
        end else if (rst_user) begin
            vld_pipe_q <= '0;
            chg_q      <= 1'b0;
            sw_event_q <= 1'b0;
            s_q        <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], step};
            chg_q      <= step & (|chg);
            sw_event_q <= chg_q;
            if (step) begin
                for (int i = 0; i < 3; i++) begin
                    s_q[2*i]   <= up[i] ? ONE_SINGLE : ZERO_SINGLE;
                    s_q[2*i+1] <= dn[i] ? ONE_SINGLE : ZERO_SINGLE;
                end
            end
        end
    end

    assign bus.s1_single = s_q[0];
    assign bus.s2_single = s_q[1];
    assign bus.s3_single = s_q[2];
    assign bus.s4_single = s_q[3];
    assign bus.s5_single = s_q[4];
    assign bus.s6_single = s_q[5];
    assign bus.sw_event  = sw_event_q;
    assign bus.done_sig  = vld_pipe_q[STAGES];

`ifdef GATE_STATS_EN
    assign bus.sw_cnt_a = sw_cnt[0];
    assign bus.sw_cnt_b = sw_cnt[1];
    assign bus.sw_cnt_c = sw_cnt[2];
`endif
endmodule

// File: doc/gate_deadtime_water.md
Name: gate_deadtime_water

Overview:
- Downstream of the rectifier control stage.
- Consumes the per-step upper-switch commands m1/m3/m5 (IEEE single, 0.0/1.0) and derives all six switch states for the converter model in the solver.
- Inserts a dead time, counted in simulation steps, on every commutation, so upper and lower switches of a leg are never both on.
- Flags any switch-state change so the solver can refresh its conductance matrix.

Parameters:
- DEADTIME_STEPS, 2, blanking length in simulation steps (0..255); 0 = pure complementary, no blanking.
- ONE_SINGLE, 32'h3F800000, encoding driven for an "on" switch.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rst_user  in  1  synchronous user reset, same effect as rst
- sta  in  1  one-cycle step strobe (from comparator done)
- m1_single  in  32  phase-a upper command
- m3_single  in  32  phase-b upper command
- m5_single  in  32  phase-c upper command
- s1_single..s6_single  out  32 each  switch states (odd = upper, even = lower; a=1/2, b=3/4, c=5/6)
- sw_event  out  1  pulse: at least one switch state changed this step
- done_sig  out  1  pulse: outputs valid for this step

Behaviour:
- Reset (rst or rst_user) values:
  - all s*_single = 32'h00000000; sw_event = 0; done_sig = 0.
  - every leg in state START, counter = 0.
- rst_user has priority over a coincident sta.
- Command decode: a command is "on" iff bits[30:0] != 0. -0.0 and 0.0 are off; any nonzero value is on.
- Timing, for sta at cycle t:
  - commands sampled at t.
  - leg FSMs update and s* registered at t+1.
  - done_sig high for exactly cycle t+2.
  - sw_event high at t+2 iff any s* differs from its value before t+1.
- Without sta, the outputs hold.
- Per-leg FSM, one transition per sta:
  - START: both off. Next sta loads counter = DEADTIME_STEPS and goes to DEAD. If DEADTIME_STEPS = 0, it goes directly to UPPER or LOWER per the command.
  - UPPER: upper on, lower off. Command off → DEAD, counter = DEADTIME_STEPS, both off. If DEADTIME_STEPS = 0, go directly to LOWER.
  - LOWER: mirror of UPPER. Command on → DEAD.
  - DEAD: both off.
    - Each sta with counter > 1 decrements the counter.
    - With counter ≤ 1, go to UPPER or LOWER per the command sampled at that sta.
    - A command reversal during DEAD does not restart or shorten the blanking; the final command wins.
- Dead time observed at the outputs = exactly DEADTIME_STEPS steps with both switches off.
- Invariant: the upper and lower outputs of a leg are never both ONE_SINGLE in any cycle.
- sta re-asserted before done_sig of the previous step: the new step is processed normally. Each sta produces exactly one done_sig pulse, two cycles later.
- rst mid-blanking: leg returns to START. The counter is not preserved.

Optional Feature:
- GATE_STATS_EN defined:
  - adds outputs sw_cnt_a, sw_cnt_b, sw_cnt_c, 16 bits each.
  - each counts the leg's UPPER→DEAD and LOWER→DEAD transitions, plus direct UPPER↔LOWER transitions when DEADTIME_STEPS = 0.
  - counts saturate at 16'hFFFF; cleared by rst/rst_user.
- Undefined: ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Shared package:
  - ONE_SINGLE and ZERO_SINGLE constants.
  - leg state encoding (START = 2'd0, UPPER = 2'd1, LOWER = 2'd2, DEAD = 2'd3).
  - counter width constant (8).
- Sub-module gate_deadtime_leg, instantiated three times.
  - Inputs: clk, rst, clr, step, cmd.
  - Outputs: up, dn, changed, plus the optional count.
- Top level holds the command decode, the sta pipeline, the OR of the changed signals and the float output registers.

Test Plan:
- Reset, then a single sta with m1 = 1.0 at DEADTIME_STEPS = 2 → s1 = s2 = 0 for 2 steps. On the third step s1 = 3F800000, s2 = 0, and sw_event pulses on that step only.
- Phase a in UPPER, m1 changes 1.0→0.0 → s1 = 0 at t+1 with sw_event at t+2. Both off for 2 steps, then s2 = 3F800000.
- During DEAD, m1 toggles 0→1→0 on successive steps → blanking still lasts exactly 2 steps and the leg ends in LOWER.
- DEADTIME_STEPS = 0, m3 alternating every step → s3/s4 complement on each step. sw_event on every step; s3 & s4 are never both on.
- rst_user asserted with sta in the same cycle while a leg is in DEAD → all outputs 0, no done_sig. Next sta restarts blanking from START.
- GATE_STATS_EN, 70000 commutations on phase c → sw_cnt_c = FFFF; rst clears it to 0.
